// File: rtl/pmod_adc_responder.sv
// SPI-slave emulation of a two-channel 12-bit Pmod ADC: two data lines shifted out MSB first behind one cs/sclk.
// Define PMOD_ADC_RAMP_EN to send an internal ramp (d0) and its inverse (d1) instead of value0/value1.

module pmod_adc_lane #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [DATA_W-1:0] value,
  output logic              d
);
  logic [FRAME_BITS-1:0] init;
  // Holds only the bits not yet on the line; d is the current bit.
  logic [FRAME_BITS-2:0] sh;

  assign init = {{LEAD_ZEROS{1'b0}}, value};

  always_ff @(posedge clk) begin
    if (!reset) begin
      sh <= '0;
      d  <= 1'b0;
    end else if (clear) begin
      d <= 1'b0;
    end else if (load) begin
      sh <= init[FRAME_BITS-2:0];
      d  <= init[FRAME_BITS-1];
    end else if (shift_en) begin
      sh <= {sh[FRAME_BITS-3:0], 1'b0};
      d  <= sh[FRAME_BITS-2];
    end
  end
endmodule

module pmod_adc_responder #(
  parameter int DATA_W     = 12,
  parameter int LEAD_ZEROS = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic [DATA_W-1:0] value0,
  input  logic [DATA_W-1:0] value1,
  output logic              spi_d0,
  output logic              spi_d1,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);
  localparam int NUM_CH = 2;
  localparam int CNT_W  = $clog2(FRAME_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                         state;
  logic [CNT_W-1:0]               count;
  logic [2:0]                     cs_sync, sclk_sync;
  logic [1:0]                     settle;
  logic                           cs_fall, cs_rise, sclk_fall;
  logic                           load, shift_en, last, abort;
  logic [NUM_CH-1:0][DATA_W-1:0]  ch_val;
  logic [NUM_CH-1:0]              ch_d;

  // Chains preset high; settle blocks the false cs fall seen when cs is low at reset release.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_sync   <= 3'b111;
      sclk_sync <= 3'b111;
      settle    <= 2'd0;
    end else begin
      cs_sync   <= {cs_sync[1:0], spi_cs_n};
      sclk_sync <= {sclk_sync[1:0], spi_sclk};
      if (settle != 2'd3) settle <= settle + 2'd1;
    end
  end

  assign cs_fall   = (settle == 2'd3) && !cs_sync[1] && cs_sync[2];
  assign cs_rise   = cs_sync[1] && !cs_sync[2];
  assign sclk_fall = !sclk_sync[1] && sclk_sync[2];

  // cs rise outranks a coincident sclk fall.
  assign load     = (state == IDLE) && cs_fall;
  assign abort    = (state == SHIFT) && cs_rise;
  assign last     = (state == SHIFT) && !cs_rise && sclk_fall && (count == LAST_BIT);
  assign shift_en = (state == SHIFT) && !cs_rise && sclk_fall && (count != LAST_BIT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: if (load) begin
          state <= SHIFT;
          count <= '0;
          busy  <= 1'b1;
        end
        SHIFT: begin
          if (abort) begin
            state     <= IDLE;
            count     <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end else if (last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end else if (shift_en) begin
            count <= count + CNT_W'(1);
          end
        end
        DONE: if (cs_rise) begin
          state <= IDLE;
          count <= '0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PMOD_ADC_RAMP_EN
  logic [DATA_W-1:0] ramp;

  always_ff @(posedge clk) begin
    if (!reset)    ramp <= '0;
    else if (last) ramp <= ramp + DATA_W'(1);
  end

  assign ch_val[0] = ramp;
  assign ch_val[1] = ~ramp;
`else
  assign ch_val[0] = value0;
  assign ch_val[1] = value1;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    pmod_adc_lane #(
      .DATA_W     (DATA_W),
      .LEAD_ZEROS (LEAD_ZEROS),
      .FRAME_BITS (FRAME_BITS)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .shift_en (shift_en),
      .clear    (abort | last),
      .value    (ch_val[i]),
      .d        (ch_d[i])
    );
  end

  assign spi_d0 = ch_d[0];
  assign spi_d1 = ch_d[1];
endmodule
